// File: rtl/cart_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cart_bus_responder: CPU cartridge-bus slave with internal RAM, bank        |
// | register, status and external memory. Optional macro: CART_BUS_TIMEOUT_EN  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cart_bus_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] ab,
    input  logic [7:0]  dbo,
    input  logic        we,
    output logic [7:0]  dbi,
    output logic        ready,
    output logic [18:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0]  OPEN_BUS   = 8'hFF;
    localparam logic [4:0]  FIXED_BANK = 5'd31;
    localparam logic [15:0] BANK_ADDR  = 16'h6000;
    localparam logic [15:0] STAT_ADDR  = 16'h6001;

    state_t      state, state_nx;
    logic [7:0]  dbi_nx;
    logic        ready_nx;
    logic [18:0] mem_addr_nx;
    logic        mem_rd_nx;
    logic        mem_wr_nx;
    logic [7:0]  mem_wdata_nx;
    logic [4:0]  bank, bank_nx;
    logic        err;
    logic        ram_we;
    logic        ram_sel;
    logic        bank_sel;
    logic        stat_sel;
    logic        ext_sel;
    logic [18:0] ext_addr;
    logic [7:0]  ram [0:2047];

`ifdef CART_BUS_TIMEOUT_EN
    logic        err_nx;
    logic [7:0]  tmo_cnt, tmo_cnt_nx;
`else
    assign err = 1'b0;
`endif

    assign ram_sel  = (ab[15:11] == 5'd0);
    assign bank_sel = (ab == BANK_ADDR);
    assign stat_sel = (ab == STAT_ADDR);
    assign ext_sel  = ab[15];
    // ab[14] separates the fixed upper window from the switchable lower one
    assign ext_addr = ab[14] ? {FIXED_BANK, ab[13:0]} : {bank, ab[13:0]};

    always_comb begin
        state_nx     = state;
        dbi_nx       = dbi;
        ready_nx     = ready;
        mem_addr_nx  = mem_addr;
        mem_rd_nx    = mem_rd;
        mem_wr_nx    = mem_wr;
        mem_wdata_nx = mem_wdata;
        bank_nx      = bank;
        ram_we       = 1'b0;
`ifdef CART_BUS_TIMEOUT_EN
        err_nx       = err;
        tmo_cnt_nx   = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (enable) begin
                    if (ram_sel) begin
                        if (we) ram_we = 1'b1;
                        else    dbi_nx = ram[ab[10:0]];
                    end else if (bank_sel) begin
                        if (we) bank_nx = dbo[4:0];
                        else    dbi_nx  = {3'b000, bank};
                    end else if (stat_sel) begin
                        if (!we) dbi_nx = {1'b0, 6'b0, err};
`ifdef CART_BUS_TIMEOUT_EN
                        else     err_nx = 1'b0;
`endif
                    end else if (ext_sel) begin
                        state_nx     = ACCESS;
                        ready_nx     = 1'b0;
                        mem_rd_nx    = ~we;
                        mem_wr_nx    = we;
                        mem_addr_nx  = ext_addr;
                        mem_wdata_nx = dbo;
`ifdef CART_BUS_TIMEOUT_EN
                        tmo_cnt_nx   = 8'd0;
`endif
                    end else if (!we) begin
                        dbi_nx = OPEN_BUS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    if (mem_rd) dbi_nx = mem_rdata;
                    mem_rd_nx = 1'b0;
                    mem_wr_nx = 1'b0;
                    ready_nx  = 1'b1;
                    state_nx  = IDLE;
                end
`ifdef CART_BUS_TIMEOUT_EN
                else if (tmo_cnt == 8'hFF) begin
                    if (mem_rd) dbi_nx = OPEN_BUS;
                    mem_rd_nx = 1'b0;
                    mem_wr_nx = 1'b0;
                    ready_nx  = 1'b1;
                    err_nx    = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 8'd1;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dbi       <= OPEN_BUS;
            ready     <= 1'b1;
            mem_addr  <= 19'd0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= 8'd0;
            bank      <= 5'd0;
        end else begin
            state     <= state_nx;
            dbi       <= dbi_nx;
            ready     <= ready_nx;
            mem_addr  <= mem_addr_nx;
            mem_rd    <= mem_rd_nx;
            mem_wr    <= mem_wr_nx;
            mem_wdata <= mem_wdata_nx;
            bank      <= bank_nx;
        end
    end

`ifdef CART_BUS_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            tmo_cnt <= 8'd0;
        end else begin
            err     <= err_nx;
            tmo_cnt <= tmo_cnt_nx;
        end
    end
`endif

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) ram[ab[10:0]] <= dbo;
    end

endmodule
`default_nettype wire

// File: tb/tb_cart_bus_responder.sv
`default_nettype none
// Testbench for cart_bus_responder: vector table with a dbi scoreboard plus
// hand-written sequences for ignored enables, stalls/timeouts and reset aborts.
module tb_cart_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] ab;
    logic [7:0]  dbo;
    logic        we;
    logic [7:0]  dbi;
    logic        ready;
    logic [18:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [15:0] ab;
        logic [7:0]  dbo;
        logic        ext;
        logic [18:0] addr;
        logic [7:0]  rdata;
        int          delay;
        logic [7:0]  dbi;
    } vec_t;

    vec_t vecs[19];

    always #5 clk = ~clk;

    cart_bus_responder dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ab        (ab),
        .dbo       (dbo),
        .we        (we),
        .dbi       (dbi),
        .ready     (ready),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at a negedge with enable low.
    task automatic run_vec(input vec_t v);
        enable = 1'b1;
        we     = v.we;
        ab     = v.ab;
        dbo    = v.dbo;
        exp_q.push_back(v.dbi);
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        if (v.ext) begin
            check("ext_ready_low", {31'd0, ready}, 32'd0);
            check("ext_strobes", {30'd0, mem_rd, mem_wr}, {30'd0, ~v.we, v.we});
            check("ext_addr", {13'd0, mem_addr}, {13'd0, v.addr});
            if (v.we) check("ext_wdata", {24'd0, mem_wdata}, {24'd0, v.dbo});
            for (int i = 0; i < v.delay; i++) begin
                @(posedge clk);
                @(negedge clk);
                check("ext_hold", {10'd0, ready, mem_rd, mem_wr, mem_addr},
                      {10'd0, 1'b0, ~v.we, v.we, v.addr});
            end
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            @(posedge clk);
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
            check("ext_done", {29'd0, ready, mem_rd, mem_wr}, {29'd0, 3'b100});
        end else begin
            check("int_ready", {31'd0, ready}, 32'd1);
        end
        check("dbi", {24'd0, dbi}, {24'd0, exp_q.pop_front()});
    endtask

    task automatic simple(input logic w, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] exp_dbi);
        vec_t v;
        v = '{w, a, d, 1'b0, 19'h0, 8'h00, 0, exp_dbi};
        run_vec(v);
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b1, 16'h0123, 8'h5A, 1'b0, 19'h00000, 8'h00, 0, 8'hFF};
        vecs[1]  = '{1'b0, 16'h0123, 8'h00, 1'b0, 19'h00000, 8'h00, 0, 8'h5A};
        vecs[2]  = '{1'b1, 16'h07FF, 8'hC3, 1'b0, 19'h00000, 8'h00, 0, 8'h5A};
        vecs[3]  = '{1'b0, 16'h07FF, 8'h00, 1'b0, 19'h00000, 8'h00, 0, 8'hC3};
        vecs[4]  = '{1'b0, 16'h0800, 8'h00, 1'b0, 19'h00000, 8'h00, 0, 8'hFF};
        vecs[5]  = '{1'b1, 16'h6000, 8'hE3, 1'b0, 19'h00000, 8'h00, 0, 8'hFF};
        vecs[6]  = '{1'b0, 16'h6000, 8'h00, 1'b0, 19'h00000, 8'h00, 0, 8'h03};
        vecs[7]  = '{1'b0, 16'h8010, 8'h00, 1'b1, 19'h0C010, 8'hA7, 0, 8'hA7};
        vecs[8]  = '{1'b0, 16'hFFFC, 8'h00, 1'b1, 19'h7FFFC, 8'h3C, 2, 8'h3C};
        vecs[9]  = '{1'b0, 16'h4000, 8'h00, 1'b0, 19'h00000, 8'h00, 0, 8'hFF};
        vecs[10] = '{1'b1, 16'hBFFF, 8'h99, 1'b1, 19'h0FFFF, 8'h66, 1, 8'hFF};
        vecs[11] = '{1'b0, 16'h6001, 8'h00, 1'b0, 19'h00000, 8'h00, 0, 8'h00};
        vecs[12] = '{1'b1, 16'h0000, 8'h11, 1'b0, 19'h00000, 8'h00, 0, 8'h00};
        vecs[13] = '{1'b0, 16'h0000, 8'h00, 1'b0, 19'h00000, 8'h00, 0, 8'h11};
        vecs[14] = '{1'b0, 16'h0123, 8'h00, 1'b0, 19'h00000, 8'h00, 0, 8'h5A};
        vecs[15] = '{1'b1, 16'h6000, 8'h1F, 1'b0, 19'h00000, 8'h00, 0, 8'h5A};
        vecs[16] = '{1'b0, 16'hC000, 8'h00, 1'b1, 19'h7C000, 8'h42, 0, 8'h42};
        vecs[17] = '{1'b0, 16'h8000, 8'h00, 1'b1, 19'h7C000, 8'h81, 3, 8'h81};
        vecs[18] = '{1'b0, 16'h5FFF, 8'h00, 1'b0, 19'h00000, 8'h00, 0, 8'hFF};

        rst = 1'b1; enable = 1'b0; we = 1'b0; ab = 16'h0; dbo = 8'h0;
        mem_rdata = 8'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_dbi", {24'd0, dbi}, 32'hFF);
        check("rst_ready_strobes", {29'd0, ready, mem_rd, mem_wr}, {29'd0, 3'b100});
        check("rst_addr_wdata", {5'd0, mem_addr, mem_wdata}, 32'd0);

        for (int i = 0; i < 19; i++) run_vec(vecs[i]);

        // mem_ack while idle must not disturb anything
        mem_ack = 1'b1; mem_rdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        check("idle_ack", {21'd0, dbi, ready, mem_rd, mem_wr}, {21'd0, 8'hFF, 3'b100});

        // enable during ACCESS is ignored: bank write attempt and address stability
        enable = 1'b1; we = 1'b0; ab = 16'h8004; dbo = 8'h00;
        @(posedge clk);
        @(negedge clk);
        we = 1'b1; ab = 16'h6000; dbo = 8'h05;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("busy_ignore", {12'd0, ready, mem_rd, mem_wr, mem_addr}, {12'd0, 3'b010, 19'h7C004});
        end
        enable = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h3E;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("busy_done_dbi", {24'd0, dbi}, 32'h3E);
        simple(1'b0, 16'h6000, 8'h00, 8'h1F);

        // withheld mem_ack: stall forever, or time out after 256 ACCESS cycles
        enable = 1'b1; we = 1'b0; ab = 16'h9000;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        check("stall_addr", {13'd0, mem_addr}, 32'h7D000);
        n = 0;
        while (ready == 1'b0 && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
`ifdef CART_BUS_TIMEOUT_EN
        check("timeout_cycles", n, 256);
        check("timeout_dbi", {22'd0, dbi, mem_rd, mem_wr}, {22'd0, 8'hFF, 2'b00});
        simple(1'b0, 16'h6001, 8'h00, 8'h01);
        simple(1'b1, 16'h6001, 8'h00, 8'h01);
        simple(1'b0, 16'h6001, 8'h00, 8'h00);
`else
        check("stall_cycles", n, 300);
        check("stall_strobe", {31'd0, mem_rd}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 8'h12;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("stall_done", {23'd0, dbi, ready}, {23'd0, 8'h12, 1'b1});
        simple(1'b0, 16'h6001, 8'h00, 8'h00);
`endif

        // reset during ACCESS aborts at once; a late ack is ignored
        enable = 1'b1; we = 1'b0; ab = 16'hA000;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        check("pre_rst_access", {12'd0, ready, mem_rd, mem_wr, mem_addr}, {12'd0, 3'b010, 19'h7E000});
        #2 rst = 1'b1;
        #1;
        check("async_rst", {21'd0, dbi, ready, mem_rd, mem_wr}, {21'd0, 8'hFF, 3'b100});
        check("async_rst_addr", {13'd0, mem_addr}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h55;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack", {21'd0, dbi, ready, mem_rd, mem_wr}, {21'd0, 8'hFF, 3'b100});
        simple(1'b0, 16'h6000, 8'h00, 8'h00);
        simple(1'b0, 16'h0123, 8'h00, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
